// File: rtl/tt_matthewelse_pkg.sv
// Shared opcode, flag-index and pin constants for the matthewelse accumulator tile.
package tt_matthewelse_pkg;

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_XOR  = 3'd5,
      OP_SHL  = 3'd6,
      OP_ROR  = 3'd7
   } opcode_t;

   localparam int FLAG_Z = 7;
   localparam int FLAG_C = 6;
   localparam int FLAG_V = 5;
   localparam int FLAG_N = 4;

   localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

endpackage

// File: rtl/matthewelse_alu.sv
// Combinational 8-bit ALU producing result and Z/C/V/N flags.
// Define ALU_SAT_EN for unsigned-saturating ADD/SUB.
module matthewelse_alu
   import tt_matthewelse_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  opcode_t    op,
   output logic [7:0] r,
   output logic       c,
   output logic       v,
   output logic       z,
   output logic       n
);

   logic [8:0] sum;
   logic [8:0] dif;
   logic [8:0] shl;
   logic [7:0] rot;

   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      // bit 8 holds the last bit pushed out of the byte
      shl = {1'b0, a} << b[2:0];
      rot = 8'({a, a} >> b[2:0]);
      r = 8'h00;
      c = 1'b0;
      v = 1'b0;
      unique case (op)
         OP_LOAD: r = b;
         OP_ADD: begin
            r = sum[7:0];
            c = sum[8];
            v = (a[7] == b[7]) && (sum[7] != a[7]);
`ifdef ALU_SAT_EN
            if (sum[8]) r = 8'hFF;
`endif
         end
         OP_SUB: begin
            r = dif[7:0];
            c = dif[8];
            v = (a[7] != b[7]) && (dif[7] != a[7]);
`ifdef ALU_SAT_EN
            if (dif[8]) r = 8'h00;
`endif
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: begin
            r = shl[7:0];
            c = shl[8];
         end
         OP_ROR: r = rot;
      endcase
      z = (r == 8'h00);
      n = r[7];
   end

endmodule

// File: rtl/tt_um_matthewelse.sv
// Accumulator ALU tile: registers acc and flags, qualifies ena/op_valid, maps pins.
// Build option ALU_SAT_EN selects saturating ADD/SUB inside the ALU.
module tt_um_matthewelse
   import tt_matthewelse_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] acc;
   logic       z, c, v, n;
   logic [7:0] alu_r;
   logic       alu_z, alu_c, alu_v, alu_n;
   logic       exec;
   opcode_t    op;
   logic       unused_pins;

   assign op          = opcode_t'(uio_in[2:0]);
   assign exec        = ena && uio_in[3];
   assign unused_pins = &{1'b0, uio_in[7:4]};

   matthewelse_alu u_alu (
      .a  (acc),
      .b  (ui_in),
      .op (op),
      .r  (alu_r),
      .c  (alu_c),
      .v  (alu_v),
      .z  (alu_z),
      .n  (alu_n)
   );

   // rst_n is active-high despite its name
   always_ff @(posedge clk) begin
      if (rst_n) begin
         acc <= 8'h00;
         z   <= 1'b1;
         c   <= 1'b0;
         v   <= 1'b0;
         n   <= 1'b0;
      end else if (exec) begin
         acc <= alu_r;
         z   <= alu_z;
         c   <= alu_c;
         v   <= alu_v;
         n   <= alu_n;
      end
   end

   always_comb begin
      uio_out         = 8'h00;
      uio_out[FLAG_Z] = z;
      uio_out[FLAG_C] = c;
      uio_out[FLAG_V] = v;
      uio_out[FLAG_N] = n;
   end

   assign uo_out = acc;
   assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_matthewelse.sv
// Self-checking bench for tt_um_matthewelse: directed plan plus random ops vs. model.
module tb_tt_um_matthewelse;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total = 0;
   int bad   = 0;

   int m_acc;
   bit m_z, m_c, m_v, m_n;

   always #5 clk = ~clk;

   tt_um_matthewelse dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // drive at negedge, take one rising edge, return at next negedge
   task automatic step(input bit r, input bit e, input bit val,
                       input int op, input int b, input int junk);
      rst_n  = r;
      ena    = e;
      ui_in  = 8'(b);
      uio_in = {4'(junk), val, 3'(op)};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_acc = 0;
      m_z = 1; m_c = 0; m_v = 0; m_n = 0;
   endtask

   task automatic model_exec(input int op, input int b);
      int a, r, sa, sb, sr, amt;
      bit c, v;
      a = m_acc;
      c = 0; v = 0; r = 0;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      amt = b % 8;
      case (op)
         0: r = b;
         1: begin
            r = a + b;
            c = (r > 255);
            sr = sa + sb;
            v = (sr > 127) || (sr < -128);
            r = r % 256;
`ifdef ALU_SAT_EN
            if (c) r = 255;
`endif
         end
         2: begin
            r = a - b;
            c = (a < b);
            sr = sa - sb;
            v = (sr > 127) || (sr < -128);
            r = (r + 256) % 256;
`ifdef ALU_SAT_EN
            if (c) r = 0;
`endif
         end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: begin
            r = (a * (1 << amt)) % 256;
            c = (amt == 0) ? 0 : ((a >> (8 - amt)) & 1) == 1;
         end
         default: r = ((a >> amt) | (a << (8 - amt))) % 256;
      endcase
      m_acc = r;
      m_c = c; m_v = v;
      m_z = (r == 0);
      m_n = (r >= 128);
   endtask

   function automatic logic [7:0] m_flags();
      return {m_z, m_c, m_v, m_n, 4'b0000};
   endfunction

   task automatic test_reset();
      step(1, 1, 1, 0, 8'h33, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      model_reset();
      total++;
      if (uo_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_acc got=%h exp=00", uo_out);
      end
      total++;
      if (uio_out !== 8'h80) begin
         bad++;
         $display("FAIL reset_flags got=%h exp=80", uio_out);
      end
      total++;
      if (uio_oe !== 8'hF0) begin
         bad++;
         $display("FAIL reset_oe got=%h exp=F0", uio_oe);
      end
   endtask

   task automatic test_arith();
      logic [7:0] ea, ef;
      step(0, 1, 1, 0, 8'h7F, 0);
      step(0, 1, 1, 1, 8'h01, 0);
      total++;
      if (uo_out !== 8'h80 || uio_out !== 8'h30) begin
         bad++;
         $display("FAIL add_ovf got=%h/%h exp=80/30", uo_out, uio_out);
      end
      step(0, 1, 1, 0, 8'hFF, 0);
      step(0, 1, 1, 1, 8'h01, 0);
`ifdef ALU_SAT_EN
      ea = 8'hFF; ef = 8'h50;
`else
      ea = 8'h00; ef = 8'hC0;
`endif
      total++;
      if (uo_out !== ea || uio_out !== ef) begin
         bad++;
         $display("FAIL add_carry got=%h/%h exp=%h/%h", uo_out, uio_out, ea, ef);
      end
      step(0, 1, 1, 0, 8'h10, 0);
      step(0, 1, 1, 2, 8'h20, 0);
`ifdef ALU_SAT_EN
      ea = 8'h00; ef = 8'hC0;
`else
      ea = 8'hF0; ef = 8'h50;
`endif
      total++;
      if (uo_out !== ea || uio_out !== ef) begin
         bad++;
         $display("FAIL sub_borrow got=%h/%h exp=%h/%h", uo_out, uio_out, ea, ef);
      end
   endtask

   task automatic test_shift();
      step(0, 1, 1, 0, 8'h81, 0);
      step(0, 1, 1, 6, 8'h01, 0);
      total++;
      if (uo_out !== 8'h02 || uio_out !== 8'h40) begin
         bad++;
         $display("FAIL shl1 got=%h/%h exp=02/40", uo_out, uio_out);
      end
      step(0, 1, 1, 7, 8'hFA, 0);
      total++;
      if (uo_out !== 8'h80 || uio_out !== 8'h10) begin
         bad++;
         $display("FAIL ror2 got=%h/%h exp=80/10", uo_out, uio_out);
      end
   endtask

   task automatic test_gating();
      step(0, 0, 1, 0, 8'h55, 0);
      total++;
      if (uo_out !== 8'h80 || uio_out !== 8'h10) begin
         bad++;
         $display("FAIL gate_ena got=%h/%h exp=80/10", uo_out, uio_out);
      end
      step(0, 1, 0, 0, 8'h55, 4'hF);
      total++;
      if (uo_out !== 8'h80 || uio_out !== 8'h10) begin
         bad++;
         $display("FAIL gate_valid got=%h/%h exp=80/10", uo_out, uio_out);
      end
      step(1, 1, 1, 1, 8'h01, 0);
      total++;
      if (uo_out !== 8'h00 || uio_out !== 8'h80) begin
         bad++;
         $display("FAIL reset_over_op got=%h/%h exp=00/80", uo_out, uio_out);
      end
      model_reset();
   endtask

   task automatic test_random();
      int op, b, junk;
      bit r, e, val;
      for (int i = 0; i < 400; i++) begin
         r    = ($urandom_range(0, 39) == 0);
         e    = ($urandom_range(0, 7) != 0);
         val  = ($urandom_range(0, 5) != 0);
         op   = $urandom_range(0, 7);
         b    = $urandom_range(0, 255);
         junk = $urandom_range(0, 15);
         step(r, e, val, op, b, junk);
         if (r) model_reset();
         else if (e && val) model_exec(op, b);
         total++;
         if (uo_out !== 8'(m_acc) || uio_out !== m_flags()) begin
            bad++;
            $display("FAIL rand[%0d] op=%0d b=%h got=%h/%h exp=%h/%h",
                     i, op, b, uo_out, uio_out, 8'(m_acc), m_flags());
         end
      end
   endtask

   task automatic test_back_to_back();
      int b;
      model_reset();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) begin
         b = $urandom_range(0, 255);
         step(0, 1, 1, i % 8, b, 0);
         model_exec(i % 8, b);
         total++;
         if (uo_out !== 8'(m_acc) || uio_out !== m_flags()) begin
            bad++;
            $display("FAIL b2b[%0d] got=%h/%h exp=%h/%h",
                     i, uo_out, uio_out, 8'(m_acc), m_flags());
         end
      end
   endtask

   initial begin
      rst_n = 1; ena = 0; ui_in = 0; uio_in = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_arith();
      test_shift();
      test_gating();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
